// File: rtl/mem_trace_fifo_if.sv
// Bus bundles for the memory-trace capture FIFO.
// mem_trace_bus_if carries the observed core memory bus; mem_trace_out_if is the drain stream.
interface mem_trace_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_instr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;
    logic [PC_W-1:0]       pc;

    modport master (
        output mem_valid, mem_ready, mem_instr, mem_addr,
        output mem_wdata, mem_wstrb, mem_rdata, pc
    );
    modport slave (
        input mem_valid, mem_ready, mem_instr, mem_addr,
        input mem_wdata, mem_wstrb, mem_rdata, pc
    );
endinterface

interface mem_trace_out_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_instr;
    logic [DATA_W/8-1:0]   out_wstrb;
    logic [ADDR_W-1:0]     out_addr;
    logic [DATA_W-1:0]     out_data;
    logic [PC_W-1:0]       out_pc;

    modport master (
        output out_valid, out_instr, out_wstrb, out_addr, out_data, out_pc,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_instr, out_wstrb, out_addr, out_data, out_pc,
        output out_ready
    );
endinterface

// File: rtl/mem_trace_fifo.sv
// Capture FIFO for picorv32 memory transactions: one bundled entry per transaction,
// first-word fall-through drain, drop/overwrite overflow policy and status counters.
module mem_trace_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int PC_W         = 32,
    parameter int CAPTURE_MODE = 1,
    parameter int OVERWRITE    = 0,
    localparam int STRB_W      = DATA_W / 8,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    mem_trace_bus_if.slave      bus,
    mem_trace_out_if.master     out,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic [15:0]         overflow_cnt
);
    localparam int ENTRY_W = 1 + STRB_W + ADDR_W + DATA_W + PC_W;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] store_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [15:0]      ovf_reg, ovf_next;
    logic             pending_reg, pending_next;

    logic              handshake, push, pop, overflow, do_write, rd_adv;
    logic              full_int, empty_int;
    logic [DATA_W-1:0] cap_data;
    logic [ENTRY_W-1:0] wr_entry;

    logic              head_instr;
    logic [STRB_W-1:0] head_wstrb;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [PC_W-1:0]   head_pc;

    always_comb begin
        handshake = bus.mem_valid & bus.mem_ready;
        full_int  = (count_reg == CNT_FULL);
        empty_int = (count_reg == '0);

        // Completion capture logs read data for loads; request capture only sees write data.
        if (CAPTURE_MODE != 0) begin
            push     = handshake;
            cap_data = (bus.mem_wstrb != '0) ? bus.mem_wdata : bus.mem_rdata;
        end else begin
            push     = bus.mem_valid & ~pending_reg;
            cap_data = bus.mem_wdata;
        end

        pop      = ~empty_int & out.out_ready;
        overflow = push & full_int & ~pop;
        do_write = push & (~full_int | pop | (OVERWRITE != 0));
        // Overwriting the oldest entry drags the read pointer along with the write.
        rd_adv   = pop | (overflow & (OVERWRITE != 0));
        wr_entry = {bus.mem_instr, bus.mem_wstrb, bus.mem_addr, cap_data, bus.pc};
    end

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        ovf_next     = ovf_reg;
        pending_next = pending_reg;

        if (do_write)
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (rd_adv)
            rd_ptr_next = rd_ptr_reg + PTR_ONE;

        case ({do_write, rd_adv})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase

        if (overflow && ovf_reg != 16'hFFFF)
            ovf_next = ovf_reg + 16'd1;

        // A request captured while memory is stalling must not be captured again.
        if (push && !bus.mem_ready)
            pending_next = 1'b1;
        else if (handshake)
            pending_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            store_mem[wr_ptr_reg] <= wr_entry;
    end

    // Head is read combinationally so a pushed entry is visible right after its edge.
    assign {head_instr, head_wstrb, head_addr, head_data, head_pc} = store_mem[rd_ptr_reg];

    assign out.out_valid = ~empty_int;
    assign out.out_instr = head_instr & ~empty_int;
    assign out.out_wstrb = empty_int ? '0 : head_wstrb;
    assign out.out_addr  = empty_int ? '0 : head_addr;
    assign out.out_data  = empty_int ? '0 : head_data;
    assign out.out_pc    = empty_int ? '0 : head_pc;

    assign count        = count_reg;
    assign full         = full_int;
    assign empty        = empty_int;
    assign overflow_cnt = ovf_reg;
endmodule

// File: tb/tb_mem_trace_fifo.sv
// Directed bench for mem_trace_fifo: four instances (completion, request capture,
// depth-4 drop, depth-4 overwrite) share one observed bus.
module tb_mem_trace_fifo;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    mem_trace_bus_if bus ();
    mem_trace_out_if o_m1 ();
    mem_trace_out_if o_m0 ();
    mem_trace_out_if o_dr ();
    mem_trace_out_if o_ov ();

    logic [4:0]  m1_count, m0_count;
    logic [2:0]  dr_count, ov_count;
    logic        m1_full, m0_full, dr_full, ov_full;
    logic        m1_empty, m0_empty, dr_empty, ov_empty;
    logic [15:0] m1_ovf, m0_ovf, dr_ovf, ov_ovf;

    mem_trace_fifo #(.DEPTH(16), .CAPTURE_MODE(1), .OVERWRITE(0)) u_m1 (
        .clk(clk), .resetn(resetn), .clear(clear), .bus(bus), .out(o_m1),
        .count(m1_count), .full(m1_full), .empty(m1_empty), .overflow_cnt(m1_ovf));
    mem_trace_fifo #(.DEPTH(16), .CAPTURE_MODE(0), .OVERWRITE(0)) u_m0 (
        .clk(clk), .resetn(resetn), .clear(clear), .bus(bus), .out(o_m0),
        .count(m0_count), .full(m0_full), .empty(m0_empty), .overflow_cnt(m0_ovf));
    mem_trace_fifo #(.DEPTH(4), .CAPTURE_MODE(1), .OVERWRITE(0)) u_dr (
        .clk(clk), .resetn(resetn), .clear(clear), .bus(bus), .out(o_dr),
        .count(dr_count), .full(dr_full), .empty(dr_empty), .overflow_cnt(dr_ovf));
    mem_trace_fifo #(.DEPTH(4), .CAPTURE_MODE(1), .OVERWRITE(1)) u_ov (
        .clk(clk), .resetn(resetn), .clear(clear), .bus(bus), .out(o_ov),
        .count(ov_count), .full(ov_full), .empty(ov_empty), .overflow_cnt(ov_ovf));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v, r, instr;
        logic [3:0]  wstrb;
        logic [31:0] addr, wdata, rdata, pc;
        logic        pop;
        logic [4:0]  c1;
        logic [31:0] a1, d1;
        logic        i1;
        logic [31:0] p1;
        logic [4:0]  c0;
        logic [31:0] d0;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic instr, input logic [3:0] wstrb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [31:0] pc);
        bus.mem_valid = v;
        bus.mem_ready = r;
        bus.mem_instr = instr;
        bus.mem_wstrb = wstrb;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_rdata = rdata;
        bus.pc        = pc;
    endtask

    task automatic set_ready(input logic m1, input logic m0, input logic dr, input logic ov);
        o_m1.out_ready = m1;
        o_m0.out_ready = m0;
        o_dr.out_ready = dr;
        o_ov.out_ready = ov;
    endtask

    initial begin
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
        set_ready(0, 0, 0, 0);

        // T1: reset held two cycles under random bus activity
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom), $urandom, $urandom, $urandom, $urandom);
            set_ready(1, 1, 1, 1);
            tick();
        end
        check("rst_m1_valid", 32'(o_m1.out_valid), 0);
        check("rst_m1_count", 32'(m1_count), 0);
        check("rst_m1_empty", 32'(m1_empty), 1);
        check("rst_m1_ovf", 32'(m1_ovf), 0);
        check("rst_m0_count", 32'(m0_count), 0);
        check("rst_dr_valid", 32'(o_dr.out_valid), 0);
        check("rst_dr_full", 32'(dr_full), 0);
        check("rst_ov_empty", 32'(ov_empty), 1);
        $display("reset: m1 count=%0d m0 count=%0d dr count=%0d ov count=%0d", m1_count, m0_count, dr_count, ov_count);
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
        set_ready(0, 0, 0, 0);
        resetn = 1'b1;
        tick();

        // Table: completion-capture (m1) and request-capture (m0) side by side
        vecs[0]  = '{1, 1, 0, 4'h0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h80, 0, 5'd1, 32'h100, 32'hDEADBEEF, 0, 32'h80, 5'd1, 32'h0};
        vecs[1]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        32'h0,  1, 5'd0, 32'h0,   32'h0,        0, 32'h0,  5'd0, 32'h0};
        vecs[2]  = '{1, 0, 0, 4'hF, 32'h200, 32'h12345678, 32'h0,        32'h84, 0, 5'd0, 32'h0,   32'h0,        0, 32'h0,  5'd1, 32'h12345678};
        vecs[3]  = '{1, 0, 0, 4'hF, 32'h200, 32'h12345678, 32'h0,        32'h84, 0, 5'd0, 32'h0,   32'h0,        0, 32'h0,  5'd1, 32'h12345678};
        vecs[4]  = '{1, 0, 0, 4'hF, 32'h200, 32'h12345678, 32'h0,        32'h84, 0, 5'd0, 32'h0,   32'h0,        0, 32'h0,  5'd1, 32'h12345678};
        vecs[5]  = '{1, 1, 0, 4'hF, 32'h200, 32'h12345678, 32'h0,        32'h84, 0, 5'd1, 32'h200, 32'h12345678, 0, 32'h84, 5'd1, 32'h12345678};
        vecs[6]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        32'h0,  0, 5'd1, 32'h200, 32'h12345678, 0, 32'h84, 5'd1, 32'h12345678};
        vecs[7]  = '{1, 1, 1, 4'h0, 32'h300, 32'hAAAA0000, 32'h13,       32'h90, 1, 5'd1, 32'h300, 32'h13,       1, 32'h90, 5'd1, 32'hAAAA0000};
        vecs[8]  = '{1, 1, 0, 4'h3, 32'h304, 32'h5555,     32'h77,       32'h94, 0, 5'd2, 32'h300, 32'h13,       1, 32'h90, 5'd2, 32'hAAAA0000};
        vecs[9]  = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        32'h0,  1, 5'd1, 32'h304, 32'h5555,     0, 32'h94, 5'd1, 32'h5555};
        vecs[10] = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        32'h0,  1, 5'd0, 32'h0,   32'h0,        0, 32'h0,  5'd0, 32'h0};
        vecs[11] = '{0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        32'h0,  1, 5'd0, 32'h0,   32'h0,        0, 32'h0,  5'd0, 32'h0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].r, vecs[i].instr, vecs[i].wstrb,
                  vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].pc);
            set_ready(vecs[i].pop, vecs[i].pop, 0, 0);
            tick();
            check($sformatf("v%0d_m1_count", i), 32'(m1_count), 32'(vecs[i].c1));
            check($sformatf("v%0d_m1_valid", i), 32'(o_m1.out_valid), 32'(vecs[i].c1 != 0));
            check($sformatf("v%0d_m1_addr", i), o_m1.out_addr, vecs[i].a1);
            check($sformatf("v%0d_m1_data", i), o_m1.out_data, vecs[i].d1);
            check($sformatf("v%0d_m1_instr", i), 32'(o_m1.out_instr), 32'(vecs[i].i1));
            check($sformatf("v%0d_m1_pc", i), o_m1.out_pc, vecs[i].p1);
            check($sformatf("v%0d_m0_count", i), 32'(m0_count), 32'(vecs[i].c0));
            check($sformatf("v%0d_m0_data", i), o_m0.out_data, vecs[i].d0);
            $display("vec %0d: m1 count=%0d addr=0x%08h data=0x%08h | m0 count=%0d data=0x%08h",
                     i, m1_count, o_m1.out_addr, o_m1.out_data, m0_count, o_m0.out_data);
        end

        // Depth-4 instances collected four completions above; clear them
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
        set_ready(0, 0, 0, 0);
        check("pre_clear_dr_count", 32'(dr_count), 4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_dr_count", 32'(dr_count), 0);
        check("clr_ov_count", 32'(ov_count), 0);

        // T4/T5: six completions into depth 4 without pops
        for (int a = 0; a < 6; a++) begin
            drive(1, 1, 0, 4'h0, 32'(a), 32'h0, 32'h1000 + 32'(a), 32'h200 + 32'(a));
            tick();
            $display("fill addr=%0d: dr count=%0d ovf=%0d | ov count=%0d ovf=%0d", a, dr_count, dr_ovf, ov_count, ov_ovf);
        end
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
        check("drop_count", 32'(dr_count), 4);
        check("drop_full", 32'(dr_full), 1);
        check("drop_ovf", 32'(dr_ovf), 2);
        check("drop_head_addr", o_dr.out_addr, 0);
        check("drop_head_data", o_dr.out_data, 32'h1000);
        check("ovw_count", 32'(ov_count), 4);
        check("ovw_ovf", 32'(ov_ovf), 2);
        check("ovw_head_addr", o_ov.out_addr, 2);
        check("ovw_head_data", o_ov.out_data, 32'h1002);

        // T6: full with push and pop in the same cycle
        drive(1, 1, 0, 4'h0, 32'd6, 32'h0, 32'h1006, 32'h206);
        set_ready(0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
        set_ready(0, 0, 0, 0);
        check("pp_drop_count", 32'(dr_count), 4);
        check("pp_drop_ovf", 32'(dr_ovf), 2);
        check("pp_ovw_count", 32'(ov_count), 4);
        check("pp_ovw_ovf", 32'(ov_ovf), 2);
        $display("push+pop: dr count=%0d ovf=%0d | ov count=%0d ovf=%0d", dr_count, dr_ovf, ov_count, ov_ovf);

        begin
            logic [31:0] exp_dr [4];
            logic [31:0] exp_ov [4];
            exp_dr = '{32'd1, 32'd2, 32'd3, 32'd6};
            exp_ov = '{32'd3, 32'd4, 32'd5, 32'd6};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("drain%0d_dr_addr", i), o_dr.out_addr, exp_dr[i]);
                check($sformatf("drain%0d_ov_addr", i), o_ov.out_addr, exp_ov[i]);
                check($sformatf("drain%0d_ov_pc", i), o_ov.out_pc, 32'h200 + exp_ov[i]);
                $display("drain %0d: dr addr=%0d ov addr=%0d", i, o_dr.out_addr, o_ov.out_addr);
                set_ready(0, 0, 1, 1);
                tick();
            end
        end
        set_ready(0, 0, 0, 0);
        check("drained_dr_empty", 32'(dr_empty), 1);
        check("drained_dr_valid", 32'(o_dr.out_valid), 0);
        check("drained_ov_count", 32'(ov_count), 0);
        check("drained_dr_ovf", 32'(dr_ovf), 2);

        drive(1, 1, 0, 4'h0, 32'd7, 32'h0, 32'h1007, 32'h207);
        tick();
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
        check("refill_dr_count", 32'(dr_count), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_dr_count", 32'(dr_count), 0);
        check("clear_dr_ovf", 32'(dr_ovf), 0);
        check("clear_dr_valid", 32'(o_dr.out_valid), 0);
        check("clear_ov_ovf", 32'(ov_ovf), 0);
        $display("clear: dr count=%0d ovf=%0d | ov count=%0d ovf=%0d", dr_count, dr_ovf, ov_count, ov_ovf);

        // Request capture: clear during a stalled request re-captures it
        drive(1, 0, 0, 4'hF, 32'h400, 32'h44, 32'h0, 32'hA0);
        tick();
        check("mc_first_count", 32'(m0_count), 1);
        tick();
        check("mc_stall_count", 32'(m0_count), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mc_clear_count", 32'(m0_count), 0);
        tick();
        check("mc_recap_count", 32'(m0_count), 1);
        check("mc_recap_data", o_m0.out_data, 32'h44);
        drive(1, 1, 0, 4'hF, 32'h400, 32'h44, 32'h0, 32'hA0);
        tick();
        check("mc_done_count", 32'(m0_count), 1);
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
        tick();
        check("mc_idle_count", 32'(m0_count), 1);
        $display("mode0 clear: m0 count=%0d data=0x%08h", m0_count, o_m0.out_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
